// File: rtl/bus_pkg.sv
// Shared host-bus widths, arbiter state encoding and the per-requester bus payload.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_MASK_W = 4;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_MASK_W-1:0] mask;
        logic                  ren;
        logic                  wen;
    } bus_req_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first requesting index strictly after 'last', searching upward with wrap.
module rr_priority_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] pick_idx,
    output logic                 pick_valid
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester overwrites earlier hits.
    always_comb begin
        pick_idx   = last;
        pick_valid = |req;
        cand       = last;
        for (int unsigned off = N; off >= 1; off--) begin
            cand = IDX_W'((32'(last) + off) % N);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one 32-bit host bus among NUM_HOSTS requesters,
// with the grant locked per transaction and an optional completion watchdog.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int unsigned NUM_HOSTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_HOSTS*BUS_ADDR_W-1:0]  req_address,
    input  logic [NUM_HOSTS*BUS_DATA_W-1:0]  req_data_write,
    input  logic [NUM_HOSTS*BUS_MASK_W-1:0]  req_write_mask,
    input  logic [NUM_HOSTS-1:0]             req_ren,
    input  logic [NUM_HOSTS-1:0]             req_wen,
    output logic [NUM_HOSTS*BUS_DATA_W-1:0]  req_data_read,
    output logic [NUM_HOSTS-1:0]             req_ready,
    output logic [BUS_ADDR_W-1:0]            bus_address,
    output logic [BUS_DATA_W-1:0]            bus_data_write,
    output logic [BUS_MASK_W-1:0]            bus_write_mask,
    output logic                             bus_ren,
    output logic                             bus_wen,
    input  logic [BUS_DATA_W-1:0]            bus_data_read,
    input  logic                             bus_ready,
    output logic [$clog2(NUM_HOSTS)-1:0]     grant_idx,
    output logic                             timeout_err
);

    localparam int unsigned IDX_W    = $clog2(NUM_HOSTS);
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    bus_req_t             req_pl [NUM_HOSTS];
    logic [NUM_HOSTS-1:0] req_vec;
    bus_req_t             sel;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 ready_c;
    logic                 force_c;

    // Per-requester unpacking and return-path fan-out.
    for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_slot
        assign req_pl[g] = '{
            addr:  req_address[g*BUS_ADDR_W +: BUS_ADDR_W],
            wdata: req_data_write[g*BUS_DATA_W +: BUS_DATA_W],
            mask:  req_write_mask[g*BUS_MASK_W +: BUS_MASK_W],
            ren:   req_ren[g],
            wen:   req_wen[g]
        };
        assign req_vec[g]   = req_ren[g] | req_wen[g];
        assign req_ready[g] = ready_c && (grant_idx_q == IDX_W'(g));
        assign req_data_read[g*BUS_DATA_W +: BUS_DATA_W] =
            (force_c && (grant_idx_q == IDX_W'(g))) ? '0 : bus_data_read;
    end

    rr_priority_pick #(
        .N (NUM_HOSTS)
    ) u_pick (
        .req        (req_vec),
        .last       (grant_idx_q),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign sel            = req_pl[grant_idx_q];
    assign bus_address    = sel.addr;
    assign bus_data_write = sel.wdata;
    assign bus_write_mask = sel.mask;
    assign grant_idx      = grant_idx_q;
    assign timeout_err    = force_c;

    // Next-state, watchdog and bus strobe gating.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        cnt_d       = cnt_q;
        ready_c     = 1'b0;
        force_c     = 1'b0;
        bus_ren     = 1'b0;
        bus_wen     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    cnt_d       = '0;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                bus_ren = sel.ren;
                bus_wen = sel.wen;
                if (!(sel.ren || sel.wen)) begin
                    state_d = ARB_IDLE;
                end else if (bus_ready) begin
                    ready_c = 1'b1;
                    state_d = ARB_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
                    ready_c = 1'b1;
                    force_c = 1'b1;
                    state_d = ARB_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= IDX_W'(NUM_HOSTS - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
